alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Execution stage directly downstream of the operand-entry state machine. It watches the one-hot entry state, captures `a`, `b` and `op` when entry reaches the execute state, and computes the result. Logic ops finish in one cycle; shifts and rotates iterate one bit per cycle. It registers the result and flags, and drives the value the top level shows on the display.

## Interface
- `Width`, 32, datapath width; must be a power of two, at least 4.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `a`  in  Width  operand A from the entry FSM.
- `b`  in  Width  operand B from the entry FSM; shift amount is `b[$clog2(Width)-1:0]`.
- `op`  in  4  operation code.
- `curr_state`  in  4  one-hot entry state: S0=0001, S1=0010, S2=0100, S3=1000.
- `result`  out  Width  last completed result.
- `flags`  out  5  {invalid, N, Z, C, V} of last completed op.
- `busy`  out  1  an operation is in flight.
- `done`  out  1  one-cycle pulse; `result` and `flags` updated on the same edge.
- `display`  out  Width  value selected for the display.

## Operation
- Launch condition: `curr_state==1000` and the registered previous `curr_state` is not `1000`, sampled at a rising edge. Because the previous state is a register, a fresh edge into S3 is required to launch.
- Launch edge: `a`, `b`, `op` are copied into internal registers, `busy` rises and the FSM moves IDLE→EXEC.
- A launch while `busy=1` is ignored; the operation in flight is unaffected.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT (~a).
  - 6 SLL, 7 SRL, 8 SRA, 9 ROL, 10 ROR.
  - 11 SLT: signed; result is 1 or 0.
  - 12–15 invalid: result 0, `invalid=1`, other flags 0.
- State machine:
  - IDLE: wait for a launch.
  - EXEC, non-shift op or shamt=0: write result and flags, pulse `done`, go to IDLE.
  - EXEC, shift with shamt=n>0: load work reg=a and count=n, go to SHIFT.
  - SHIFT: shift or rotate the work reg one bit per edge and decrement count. On the edge where count==1, write result and flags, pulse `done`, go to IDLE.
- Flags:
  - Z = (result==0).
  - N = result[Width-1].
  - C on ADD: carry-out.
  - C on SUB: borrow (a<b unsigned).
  - C on SLL/SRL/SRA: last bit shifted out.
  - C is 0 for all other ops, including shamt=0.
  - V: signed overflow on ADD/SUB; 0 for all other ops.
- `display` is a registered mux:
  - S0 shows the captured `a`; S1 shows the captured `b`.
  - S2 shows `{0,op}`; S3 shows `result`.
  - A non-one-hot `curr_state` shows 0.
- A non-one-hot `curr_state` never launches.

## Timing
- Reset (`rst=0`, asynchronous):
  - FSM goes to IDLE; previous-state register is 0000.
  - `result`=0, `flags`=0, `busy`=0, `done`=0, `display`=0; captured operands and work reg are 0.
- Latency, counted from the launch edge E0:
  - Non-shift ops and shamt=0: `done` at E0+1.
  - Shifts with shamt=n: `done` at E0+1+n; worst case E0+Width.
- `busy` is high from E0 until the `done` edge; it falls on the same edge `done` rises.
- A launch on the same edge as `done` is accepted: `busy` stays high.
- `result`/`flags` hold their value between `done` pulses.
- Reset asserted mid-operation: the operation is aborted with no `done`, and outputs return to reset values.
- `display` updates one edge after `curr_state` or `result` changes.

## Configuration
- `ALU_BARREL_SHIFT_EN` defined:
  - All shifts and rotates complete in EXEC through a combinational barrel shifter; the SHIFT state is not built.
  - Every op has `done` at E0+1.
- `ALU_BARREL_SHIFT_EN` undefined: iterative SHIFT state as described above.
- Results and flags are identical in both builds.

## Test plan
- ADD: a=FFFFFFFF, b=00000001, op=0 → result=00000000, flags={0,0,1,1,0}, `done` at E0+1.
- SUB: a=80000000, b=00000001, op=1 → result=7FFFFFFF, flags={0,0,0,0,1}.
- SRA: a=80000000, b=4, op=8, iterative build → `busy` high for E0..E0+5, result=F8000000, C=0, `done` at E0+5.
- Launch while busy: SLL with a=00000001, b=31, then re-entry to S3 with op=0 after 4 cycles → second launch ignored; result=80000000 at E0+32; exactly one `done`.
- Invalid: op=4'hC → result=0, flags={1,0,0,0,0}; `display` shows 0 when `curr_state`=0011.
- Reset: assert `rst=0` during SHIFT of a ROL with b=20 → `busy`=0, result=0, no `done`. Then a fresh S3 entry with ADD 2+3 gives result=5.

Source files
------------

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - ALU execution stage launched on entry to S3; ALU_BARREL_SHIFT_EN selects single-cycle shifts
module alu_exec_unit #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic [3:0]       op,
  input  logic [3:0]       curr_state,
  output logic [Width-1:0] result,
  output logic [4:0]       flags,
  output logic             busy,
  output logic             done,
  output logic [Width-1:0] display
);
  localparam int            SW  = $clog2(Width);
  localparam logic [SW-1:0] ONE = SW'(1);
  localparam logic [3:0]    S0 = 4'b0001, S1 = 4'b0010, S2 = 4'b0100, S3 = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
`ifndef ALU_BARREL_SHIFT_EN
    SHIFT,
`endif
    EXEC
  } state_t;

  state_t           state, state_nx;
  logic [3:0]       prev_state, op_q;
  logic [Width-1:0] a_q, b_q;
  logic [SW-1:0]    shamt;
  logic             launch, capture, finish;
  logic [Width:0]   sum, dif;
  logic [Width-1:0] alu_res, fin_res, display_nx;
  logic             alu_c, alu_v, alu_inv, fin_c, fin_v, fin_inv;
  logic [4:0]       fin_flags;

  assign shamt  = b_q[SW-1:0];
  assign launch = (curr_state == S3) && (prev_state != S3);
  assign busy   = (state != IDLE);

`ifdef ALU_BARREL_SHIFT_EN
  logic [Width:0]  shl, shr, sra;
  logic [SW-1:0]   neg;
`else
  logic [Width-1:0] work, work_nx;
  logic [SW-1:0]    count;
  logic             step_c, is_shift, load_shift;

  assign is_shift = (op_q >= 4'd6) && (op_q <= 4'd10);

  always_comb begin
    work_nx = work;
    step_c  = 1'b0;
    case (op_q)
      4'd6:    begin work_nx = {work[Width-2:0], 1'b0};        step_c = work[Width-1]; end
      4'd7:    begin work_nx = {1'b0, work[Width-1:1]};        step_c = work[0];       end
      4'd8:    begin work_nx = {work[Width-1], work[Width-1:1]}; step_c = work[0];     end
      4'd9:    work_nx = {work[Width-2:0], work[Width-1]};
      4'd10:   work_nx = {work[0], work[Width-1:1]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work  <= '0;
      count <= '0;
    end else if (load_shift) begin
      work  <= a_q;
      count <= shamt;
    end else if (state == SHIFT) begin
      work  <= work_nx;
      count <= count - ONE;
    end
  end
`endif

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_inv = 1'b0;
    sum = {1'b0, a_q} + {1'b0, b_q};
    dif = {1'b0, a_q} - {1'b0, b_q};
`ifdef ALU_BARREL_SHIFT_EN
    // The extra bit beside the operand catches the last bit shifted out.
    shl = {1'b0, a_q} << shamt;
    shr = {a_q, 1'b0} >> shamt;
    sra = $signed({a_q, 1'b0}) >>> shamt;
    neg = ~shamt + ONE;
`endif
    case (op_q)
      4'd0: begin
        alu_res = sum[Width-1:0];
        alu_c   = sum[Width];
        alu_v   = (a_q[Width-1] == b_q[Width-1]) && (sum[Width-1] != a_q[Width-1]);
      end
      4'd1: begin
        alu_res = dif[Width-1:0];
        alu_c   = dif[Width];
        alu_v   = (a_q[Width-1] != b_q[Width-1]) && (dif[Width-1] != a_q[Width-1]);
      end
      4'd2:  alu_res = a_q & b_q;
      4'd3:  alu_res = a_q | b_q;
      4'd4:  alu_res = a_q ^ b_q;
      4'd5:  alu_res = ~a_q;
      4'd11: alu_res = {{(Width-1){1'b0}}, $signed(a_q) < $signed(b_q)};
`ifdef ALU_BARREL_SHIFT_EN
      4'd6:  begin alu_res = shl[Width-1:0]; alu_c = shl[Width]; end
      4'd7:  begin alu_res = shr[Width:1];   alu_c = shr[0];     end
      4'd8:  begin alu_res = sra[Width:1];   alu_c = sra[0];     end
      4'd9:  alu_res = (a_q << shamt) | (a_q >> neg);
      4'd10: alu_res = (a_q >> shamt) | (a_q << neg);
`else
      4'd6, 4'd7, 4'd8, 4'd9, 4'd10: alu_res = a_q;
`endif
      default: alu_inv = 1'b1;
    endcase
  end

  always_comb begin
    finish  = 1'b0;
    fin_res = alu_res;
    fin_c   = alu_c;
    fin_v   = alu_v;
    fin_inv = alu_inv;
`ifndef ALU_BARREL_SHIFT_EN
    load_shift = 1'b0;
`endif
    case (state)
      EXEC: begin
        finish = 1'b1;
`ifndef ALU_BARREL_SHIFT_EN
        if (is_shift && shamt != '0) begin
          finish     = 1'b0;
          load_shift = 1'b1;
        end
`endif
      end
`ifndef ALU_BARREL_SHIFT_EN
      SHIFT: if (count == ONE) begin
        finish  = 1'b1;
        fin_res = work_nx;
        fin_c   = step_c;
        fin_v   = 1'b0;
        fin_inv = 1'b0;
      end
`endif
      default: ;
    endcase
    // A launch arriving on the completing edge is taken back-to-back.
    capture = launch && (state == IDLE || finish);
  end

  always_comb begin
    state_nx = state;
    if (finish) state_nx = launch ? EXEC : IDLE;
`ifndef ALU_BARREL_SHIFT_EN
    else if (load_shift) state_nx = SHIFT;
`endif
    else if (state == IDLE && launch) state_nx = EXEC;
  end

  assign fin_flags = fin_inv ? 5'b10000
                             : {1'b0, fin_res[Width-1], fin_res == '0, fin_c, fin_v};

  always_comb begin
    case (curr_state)
      S0:      display_nx = a_q;
      S1:      display_nx = b_q;
      S2:      display_nx = {{(Width-4){1'b0}}, op_q};
      S3:      display_nx = result;
      default: display_nx = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      prev_state <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      result     <= '0;
      flags      <= '0;
      done       <= 1'b0;
      display    <= '0;
    end else begin
      state      <= state_nx;
      prev_state <= curr_state;
      done       <= finish;
      display    <= display_nx;
      if (capture) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op;
      end
      if (finish) begin
        result <= fin_res;
        flags  <= fin_flags;
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - table-driven bench for alu_exec_unit
module tb_alu_exec_unit;
  localparam logic [3:0] S0 = 4'b0001, S1 = 4'b0010, S2 = 4'b0100, S3 = 4'b1000;
  localparam int NV = 19;

  logic        clk, rst;
  logic [31:0] a, b, result, display;
  logic [3:0]  op, curr_state;
  logic [4:0]  flags;
  logic        busy, done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic [4:0]  flg;
    int          lat;
  } vec_t;

  vec_t vecs[NV];

  alu_exec_unit #(.Width(32)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .curr_state(curr_state),
    .result(result), .flags(flags), .busy(busy), .done(done), .display(display)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Enter S3 from S2 and return the number of edges after E0 until done is seen.
  task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic [3:0] vop,
                        output int lat);
    @(negedge clk);
    a = va; b = vb; op = vop; curr_state = S2;
    @(negedge clk);
    curr_state = S3;
    @(posedge clk); #1;
    check("busy_at_launch", {31'b0, busy}, 32'd1);
    lat = 0;
    for (int i = 1; i <= 64 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (done) lat = i;
    end
  endtask

  initial begin
    int lat, ndone, exp_lat;

    vecs[0]  = '{"add_carry",  32'hFFFFFFFF, 32'h00000001, 4'd0,  32'h00000000, 5'b00110, 1};
    vecs[1]  = '{"sub_ovf",    32'h80000000, 32'h00000001, 4'd1,  32'h7FFFFFFF, 5'b00001, 1};
    vecs[2]  = '{"add_ovf",    32'h7FFFFFFF, 32'h00000001, 4'd0,  32'h80000000, 5'b01001, 1};
    vecs[3]  = '{"sub_borrow", 32'h00000001, 32'h00000002, 4'd1,  32'hFFFFFFFF, 5'b01010, 1};
    vecs[4]  = '{"and",        32'hF0F0F0F0, 32'h0FF00FF0, 4'd2,  32'h00F000F0, 5'b00000, 1};
    vecs[5]  = '{"or",         32'h12340000, 32'h00005678, 4'd3,  32'h12345678, 5'b00000, 1};
    vecs[6]  = '{"xor",        32'hFFFF0000, 32'hFFFFFFFF, 4'd4,  32'h0000FFFF, 5'b00000, 1};
    vecs[7]  = '{"not",        32'h00000000, 32'h12345678, 4'd5,  32'hFFFFFFFF, 5'b01000, 1};
    vecs[8]  = '{"sll",        32'hC0000001, 32'h00000001, 4'd6,  32'h80000002, 5'b01010, 2};
    vecs[9]  = '{"srl",        32'h00000003, 32'h00000002, 4'd7,  32'h00000000, 5'b00110, 3};
    vecs[10] = '{"sra",        32'h80000000, 32'h00000004, 4'd8,  32'hF8000000, 5'b01000, 5};
    vecs[11] = '{"rol",        32'h80000001, 32'h00000004, 4'd9,  32'h00000018, 5'b00000, 5};
    vecs[12] = '{"ror",        32'h00000001, 32'h00000001, 4'd10, 32'h80000000, 5'b01000, 2};
    vecs[13] = '{"slt_true",   32'hFFFFFFFF, 32'h00000001, 4'd11, 32'h00000001, 5'b00000, 1};
    vecs[14] = '{"slt_false",  32'h00000005, 32'hFFFFFFFD, 4'd11, 32'h00000000, 5'b00100, 1};
    vecs[15] = '{"sll_zero",   32'h12345678, 32'h00000020, 4'd6,  32'h12345678, 5'b00000, 1};
    vecs[16] = '{"srl_max",    32'h80000000, 32'h0000001F, 4'd7,  32'h00000001, 5'b00000, 32};
    vecs[17] = '{"invalid_f",  32'h00000000, 32'h00000000, 4'hF,  32'h00000000, 5'b10000, 1};
    vecs[18] = '{"invalid_c",  32'h00000001, 32'h00000002, 4'hC,  32'h00000000, 5'b10000, 1};

    rst = 0; a = 0; b = 0; op = 0; curr_state = 4'b0000;
    #12;
    check("rst_result",  result,        32'd0);
    check("rst_flags",   {27'b0, flags}, 32'd0);
    check("rst_busy",    {31'b0, busy},  32'd0);
    check("rst_done",    {31'b0, done},  32'd0);
    check("rst_display", display,       32'd0);
    @(negedge clk);
    rst = 1;

    for (int i = 0; i < NV; i++) begin
`ifdef ALU_BARREL_SHIFT_EN
      exp_lat = 1;
`else
      exp_lat = vecs[i].lat;
`endif
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, lat);
      check($sformatf("%s_latency", vecs[i].name), lat, exp_lat);
      check($sformatf("%s_result", vecs[i].name), result, vecs[i].res);
      check($sformatf("%s_flags", vecs[i].name), {27'b0, flags}, {27'b0, vecs[i].flg});
      @(posedge clk); #1;
      check($sformatf("%s_done_pulse", vecs[i].name), {31'b0, done}, 32'd0);
      check($sformatf("%s_display", vecs[i].name), display, vecs[i].res);
    end

    // Display mux after the invalid op captured a=1, b=2, op=C.
    @(negedge clk) curr_state = 4'b0011;
    @(posedge clk); #1;
    check("display_non_onehot", display, 32'd0);
    @(negedge clk) curr_state = S0;
    @(posedge clk); #1;
    check("display_s0", display, 32'h00000001);
    @(negedge clk) curr_state = S1;
    @(posedge clk); #1;
    check("display_s1", display, 32'h00000002);
    @(negedge clk) curr_state = S2;
    @(posedge clk); #1;
    check("display_s2", display, 32'h0000000C);
    check("non_onehot_no_launch", {31'b0, busy}, 32'd0);

`ifndef ALU_BARREL_SHIFT_EN
    // Re-entry to S3 while a long SLL is in flight must be ignored.
    @(negedge clk);
    a = 32'h00000001; b = 32'd31; op = 4'd6; curr_state = S2;
    @(negedge clk) curr_state = S3;
    @(posedge clk); #1;
    ndone = 0;
    lat = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 3) curr_state = S0;
      if (cyc == 4) begin
        curr_state = S3; a = 32'd2; b = 32'd3; op = 4'd0;
      end
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        lat = cyc;
      end
    end
    check("busy_launch_done_count", ndone, 32'd1);
    check("busy_launch_latency", lat, 32'd32);
    check("busy_launch_result", result, 32'h80000000);

    // A launch on the done edge of a ROR is accepted back-to-back.
    @(negedge clk);
    a = 32'h00000001; b = 32'd1; op = 4'd10; curr_state = S2;
    @(negedge clk) curr_state = S3;
    @(posedge clk); #1;
    @(negedge clk) curr_state = S0;
    @(negedge clk);
    curr_state = S3; a = 32'd2; b = 32'd3; op = 4'd0;
    @(posedge clk); #1;
    check("b2b_first_done",   {31'b0, done}, 32'd1);
    check("b2b_busy_held",    {31'b0, busy}, 32'd1);
    check("b2b_first_result", result, 32'h80000000);
    @(posedge clk); #1;
    check("b2b_second_done",   {31'b0, done}, 32'd1);
    check("b2b_second_result", result, 32'h00000005);
    check("b2b_idle",          {31'b0, busy}, 32'd0);
`endif

    // Reset in the middle of a ROL by 20 aborts it.
    @(negedge clk);
    a = 32'h00000001; b = 32'd20; op = 4'd9; curr_state = S2;
    @(negedge clk) curr_state = S3;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_busy_before", {31'b0, busy}, 32'd1);
    @(negedge clk);
    rst = 0; curr_state = S0;
    #1;
    check("abort_busy",    {31'b0, busy},  32'd0);
    check("abort_result",  result,        32'd0);
    check("abort_flags",   {27'b0, flags}, 32'd0);
    check("abort_display", display,       32'd0);
    ndone = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    @(negedge clk) rst = 1;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 32'd0);
    run_op(32'd2, 32'd3, 4'd0, lat);
    check("after_reset_latency", lat, 32'd1);
    check("after_reset_result", result, 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
